// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D cache to main-memory arbiter.
// FSM states, grant encoding and default bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 28;
    localparam int DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    // Grant encoding doubles as the request-vector bit index.
    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker; zero latency, no backpressure.
// On a tie the requester not served last wins.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_gnt,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_req;
        if (i_req == 2'b11) begin
            o_gnt = ~i_last;
        end else begin
            o_gnt = i_req[1];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache block transfers onto one memory port; command registered one cycle after grant.
// Requests are levels held until the cycle-aligned *_mem_ready pulse; a drain window follows every completion.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DRAIN_CYC = 1
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam logic [1:0] DRAIN_LD = DRAIN_CYC[1:0];

    arb_state_t        r_state;
    logic              r_last_gnt;
    logic [1:0]        r_drain_cnt;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_pick_gnt;
    logic              w_pick_vld;

    assign w_i_req = i_mem_read;
    assign w_d_req = d_mem_read | d_mem_write;

    rr_pick2 u_pick (
        .i_req   ({w_d_req, w_i_req}),
        .i_last  (r_last_gnt),
        .o_gnt   (w_pick_gnt),
        .o_valid (w_pick_vld)
    );

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state     <= ST_IDLE;
            r_last_gnt  <= GNT_I;
            r_drain_cnt <= 2'd0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_last_gnt <= w_pick_gnt;
                        if (w_pick_gnt == GNT_D) begin
                            r_state     <= ST_GNT_D;
                            r_mem_addr  <= d_mem_addr;
                            r_mem_wdata <= d_mem_wdata;
                            // Write-back takes precedence over a concurrent read.
                            r_mem_write <= d_mem_write;
                            r_mem_read  <= ~d_mem_write;
                        end else begin
                            r_state     <= ST_GNT_I;
                            r_mem_addr  <= i_mem_addr;
                            r_mem_read  <= 1'b1;
                            r_mem_write <= 1'b0;
                        end
                    end
                end
                ST_GNT_I, ST_GNT_D: begin
                    if (mem_ready) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_drain_cnt <= DRAIN_LD;
                        r_state     <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt <= 2'd1) begin
                        r_drain_cnt <= 2'd0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 2'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;

    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;
    assign i_mem_ready = (r_state == ST_GNT_I) && mem_ready;
    assign d_mem_ready = (r_state == ST_GNT_D) && mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 ns after the rising edge, outputs sampled on the falling edge.
module tb_mem_arbiter;

    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;

    logic              clk;
    logic              proc_reset_n;
    logic              i_mem_read;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [DATA_W-1:0] i_mem_rdata;
    logic              i_mem_ready;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [DATA_W-1:0] d_mem_wdata;
    logic [DATA_W-1:0] d_mem_rdata;
    logic              d_mem_ready;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    int n_vec;
    int n_err;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DRAIN_CYC (1)
    ) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .i_mem_read   (i_mem_read),
        .i_mem_addr   (i_mem_addr),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_ready  (i_mem_ready),
        .d_mem_read   (d_mem_read),
        .d_mem_write  (d_mem_write),
        .d_mem_addr   (d_mem_addr),
        .d_mem_wdata  (d_mem_wdata),
        .d_mem_rdata  (d_mem_rdata),
        .d_mem_ready  (d_mem_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    localparam logic [127:0] WD1 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    localparam logic [127:0] WD2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] RD1 = 128'hA5A5_A5A5_0000_0001_5A5A_5A5A_FFFF_0001;
    localparam logic [127:0] RD2 = 128'h0F0F_0F0F_1234_5678_9ABC_DEF0_0000_0002;
    localparam logic [127:0] RD3 = 128'h7777_0000_7777_0000_7777_0000_7777_0003;

    initial begin
        n_vec = 0;
        n_err = 0;
        proc_reset_n = 1'b0;
        i_mem_read   = 1'b0;
        i_mem_addr   = '0;
        d_mem_read   = 1'b0;
        d_mem_write  = 1'b0;
        d_mem_addr   = '0;
        d_mem_wdata  = '0;
        mem_rdata    = RD1;
        mem_ready    = 1'b0;

        // Reset state, with a request already pending.
        #2;
        i_mem_read = 1'b1;
        mem_ready  = 1'b1;
        #1;
        chk("rst_mem_read",  128'(mem_read),  128'h0);
        chk("rst_mem_write", 128'(mem_write), 128'h0);
        chk("rst_mem_addr",  128'(mem_addr),  128'h0);
        chk("rst_mem_wdata", mem_wdata,       128'h0);
        chk("rst_i_ready",   128'(i_mem_ready), 128'h0);
        chk("rst_d_ready",   128'(d_mem_ready), 128'h0);
        chk("rst_i_rdata",   i_mem_rdata,     RD1);
        chk("rst_d_rdata",   d_mem_rdata,     RD1);
        nxt();
        nxt();
        mem_ready = 1'b0;
        i_mem_read = 1'b0;
        proc_reset_n = 1'b1;
        nxt();

        // Tie from reset: D write first, then I read.
        i_mem_read  = 1'b1;
        i_mem_addr  = 28'h40;
        d_mem_write = 1'b1;
        d_mem_addr  = 28'h80;
        d_mem_wdata = WD1;
        nxt();
        smp();
        chk("tie_d_write",  128'(mem_write), 128'h1);
        chk("tie_d_read",   128'(mem_read),  128'h0);
        chk("tie_d_addr",   128'(mem_addr),  128'h80);
        chk("tie_d_wdata",  mem_wdata,       WD1);
        nxt();
        mem_ready = 1'b1;
        mem_rdata = RD2;
        smp();
        chk("tie_d_ready",  128'(d_mem_ready), 128'h1);
        chk("tie_d_iready", 128'(i_mem_ready), 128'h0);
        nxt();
        mem_ready   = 1'b1;
        d_mem_write = 1'b0;
        smp();
        chk("drain_spur_i", 128'(i_mem_ready), 128'h0);
        chk("drain_spur_d", 128'(d_mem_ready), 128'h0);
        chk("drain_wr_low", 128'(mem_write),   128'h0);
        nxt();
        mem_ready = 1'b0;
        smp();
        chk("idle_no_cmd",  128'(mem_read),  128'h0);
        nxt();
        smp();
        chk("tie_i_read",   128'(mem_read),  128'h1);
        chk("tie_i_write",  128'(mem_write), 128'h0);
        chk("tie_i_addr",   128'(mem_addr),  128'h40);
        chk("tie_i_wdata_hold", mem_wdata,   WD1);
        nxt();
        mem_ready = 1'b1;
        mem_rdata = RD3;
        smp();
        chk("tie_i_ready",  128'(i_mem_ready), 128'h1);
        chk("tie_i_dready", 128'(d_mem_ready), 128'h0);
        chk("tie_i_rdata",  i_mem_rdata,     RD3);
        nxt();
        mem_ready  = 1'b0;
        i_mem_read = 1'b0;
        nxt();

        // D-only read, memory answers five cycles after the request.
        d_mem_read = 1'b1;
        d_mem_addr = 28'h0000123;
        nxt();
        smp();
        chk("dro_read",  128'(mem_read), 128'h1);
        chk("dro_addr",  128'(mem_addr), 128'h123);
        chk("dro_ready_early", 128'(d_mem_ready), 128'h0);
        repeat (4) nxt();
        smp();
        chk("dro_read_held", 128'(mem_read), 128'h1);
        nxt();
        mem_ready = 1'b1;
        mem_rdata = RD1;
        smp();
        chk("dro_ready", 128'(d_mem_ready), 128'h1);
        chk("dro_rdata", d_mem_rdata,       RD1);
        nxt();
        mem_ready  = 1'b0;
        d_mem_read = 1'b0;
        smp();
        chk("dro_read_clr", 128'(mem_read), 128'h0);
        nxt();

        // Stale request held one cycle past ready: no second grant.
        d_mem_read = 1'b1;
        d_mem_addr = 28'h55;
        nxt();
        nxt();
        mem_ready = 1'b1;
        smp();
        chk("stale_ready", 128'(d_mem_ready), 128'h1);
        nxt();
        mem_ready = 1'b0;
        smp();
        chk("stale_drain", 128'(mem_read), 128'h0);
        nxt();
        d_mem_read = 1'b0;
        smp();
        chk("stale_idle", 128'(mem_read), 128'h0);
        nxt();
        smp();
        chk("stale_no_regrant", 128'(mem_read), 128'h0);

        // Request still present after drain: granted again.
        d_mem_read = 1'b1;
        d_mem_addr = 28'h66;
        nxt();
        nxt();
        mem_ready = 1'b1;
        nxt();
        mem_ready = 1'b0;
        nxt();
        smp();
        chk("held_no_grant_yet", 128'(mem_read), 128'h0);
        nxt();
        d_mem_read = 1'b0;
        smp();
        chk("held_regrant", 128'(mem_read), 128'h1);
        chk("held_regrant_addr", 128'(mem_addr), 128'h66);
        nxt();
        mem_ready = 1'b1;
        smp();
        chk("held_regrant_ready", 128'(d_mem_ready), 128'h1);
        nxt();
        mem_ready = 1'b0;
        nxt();

        // Write and read together, dropped right after grant: write wins, still completes.
        d_mem_read  = 1'b1;
        d_mem_write = 1'b1;
        d_mem_addr  = 28'h3;
        d_mem_wdata = WD2;
        nxt();
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        smp();
        chk("wr_rd_write", 128'(mem_write), 128'h1);
        chk("wr_rd_read",  128'(mem_read),  128'h0);
        chk("wr_rd_wdata", mem_wdata,       WD2);
        nxt();
        smp();
        chk("wr_noabort", 128'(mem_write), 128'h1);
        nxt();
        mem_ready = 1'b1;
        smp();
        chk("wr_noabort_ready", 128'(d_mem_ready), 128'h1);
        nxt();
        mem_ready = 1'b0;
        nxt();
        nxt();

        // Spurious memory ready while idle.
        mem_ready = 1'b1;
        smp();
        chk("spur_idle_i", 128'(i_mem_ready), 128'h0);
        chk("spur_idle_d", 128'(d_mem_ready), 128'h0);
        nxt();
        mem_ready = 1'b0;
        smp();
        chk("spur_idle_cmd", 128'(mem_read | mem_write), 128'h0);

        // Reset during GNT_I, two cycles before memory would answer.
        i_mem_read = 1'b1;
        i_mem_addr = 28'h200;
        nxt();
        smp();
        chk("rst_gnt_i_read", 128'(mem_read), 128'h1);
        chk("rst_gnt_i_addr", 128'(mem_addr), 128'h200);
        nxt();
        #1;
        proc_reset_n = 1'b0;
        #1;
        chk("mid_rst_read", 128'(mem_read), 128'h0);
        chk("mid_rst_addr", 128'(mem_addr), 128'h0);
        chk("mid_rst_wdata", mem_wdata,     128'h0);
        nxt();
        mem_ready = 1'b1;
        smp();
        chk("mid_rst_i_ready", 128'(i_mem_ready), 128'h0);
        nxt();
        mem_ready    = 1'b0;
        proc_reset_n = 1'b1;
        i_mem_addr   = 28'h40;
        d_mem_read   = 1'b1;
        d_mem_addr   = 28'h81;
        nxt();
        smp();
        chk("post_rst_tie_read", 128'(mem_read), 128'h1);
        chk("post_rst_tie_addr", 128'(mem_addr), 128'h81);
        nxt();
        mem_ready = 1'b1;
        smp();
        chk("post_rst_d_ready", 128'(d_mem_ready), 128'h1);
        chk("post_rst_i_ready", 128'(i_mem_ready), 128'h0);
        nxt();
        mem_ready  = 1'b0;
        d_mem_read = 1'b0;
        i_mem_read = 1'b0;
        repeat (2) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
